// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port shared memory.
// Each transaction takes three cycles: IDLE (sample and arbitrate), SERVE
// (memory access) and DONE (ack to the owner). The registered command drives
// the memory port. Read data is captured into the owner's rdata register at
// the edge that leaves SERVE.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: when defined, requester A always
// wins contention and there is no last-grant register. When undefined, the
// arbiter is round-robin.
module mem_arbiter #(
    parameter int word_size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 we_a,
    input  logic                 we_b,
    input  logic [word_size-1:0] addr_a,
    input  logic [word_size-1:0] addr_b,
    input  logic [word_size-1:0] wdata_a,
    input  logic [word_size-1:0] wdata_b,
    output logic                 ack_a,
    output logic                 ack_b,
    output logic [word_size-1:0] rdata_a,
    output logic [word_size-1:0] rdata_b,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [word_size-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   cmd_we_q, cmd_we_d;
    logic [word_size-1:0]   cmd_addr_q, cmd_addr_d;
    logic [word_size-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                   mem_write_q, mem_write_d;
    logic                   ack_a_q, ack_a_d;
    logic                   ack_b_q, ack_b_d;
    logic [word_size-1:0]   rdata_a_q, rdata_a_d;
    logic [word_size-1:0]   rdata_b_q, rdata_b_d;
    logic                   req_any_s;
    logic                   grant_b_s;

    // A transaction can start whenever either requester asks.
    always_comb begin
        req_any_s = req_a | req_b;
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: A wins whenever it requests; B only wins when alone.
    always_comb begin
        grant_b_s = 1'b0;
        if (req_a) begin
            grant_b_s = 1'b0;
        end else begin
            grant_b_s = req_b;
        end
    end
`else
    logic last_grant_q, last_grant_d;

    // Round-robin: on contention, the requester not granted last wins.
    always_comb begin
        grant_b_s = 1'b0;
        if (req_a && req_b) begin
            grant_b_s = (last_grant_q == OWNER_A);
        end else begin
            grant_b_s = req_b;
        end
    end

    // Record the owner of every accepted transaction as the new last grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && req_any_s) begin
            last_grant_d = grant_b_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register; resets to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWNER_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Next state, command capture, read-data capture and ack generation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        mem_write_d = 1'b0;
        ack_a_d     = 1'b0;
        ack_b_d     = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;

        case (state_q)
            IDLE: begin
                if (req_any_s) begin
                    state_d = SERVE;
                    owner_d = grant_b_s;
                    if (grant_b_s) begin
                        cmd_we_d    = we_b;
                        cmd_addr_d  = addr_b;
                        cmd_wdata_d = wdata_b;
                        mem_write_d = we_b;
                    end else begin
                        cmd_we_d    = we_a;
                        cmd_addr_d  = addr_a;
                        cmd_wdata_d = wdata_a;
                        mem_write_d = we_a;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            SERVE: begin
                // The memory access happens in this cycle. Any read result
                // goes only into the owner's register.
                state_d = DONE;
                if (owner_q == OWNER_B) begin
                    ack_b_d = 1'b1;
                    if (!cmd_we_q) begin
                        rdata_b_d = mem_rdata;
                    end else begin
                        rdata_b_d = rdata_b_q;
                    end
                end else begin
                    ack_a_d = 1'b1;
                    if (!cmd_we_q) begin
                        rdata_a_d = mem_rdata;
                    end else begin
                        rdata_a_d = rdata_a_q;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_A;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= {word_size{1'b0}};
            cmd_wdata_q <= {word_size{1'b0}};
            mem_write_q <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            rdata_a_q   <= {word_size{1'b0}};
            rdata_b_q   <= {word_size{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            mem_write_q <= mem_write_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign mem_write = mem_write_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter word_size, default 8, data and address width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req_a, req_b  input  1 each  request from requester A / B.
REQ-005 we_a, we_b  input  1 each  1 = write, 0 = read.
REQ-006 addr_a, addr_b  input  word_size each  target address.
REQ-007 wdata_a, wdata_b  input  word_size each  write data.
REQ-008 ack_a, ack_b  output  1 each  one-cycle completion pulse.
REQ-009 rdata_a, rdata_b  output  word_size each  registered read data.
REQ-010 mem_addr  output  word_size  address to the shared memory.
REQ-011 mem_wdata  output  word_size  write data to the shared memory.
REQ-012 mem_write  output  1  write strobe to the shared memory.
REQ-013 mem_rdata  input  word_size  combinational read data returned by the memory.

Function
REQ-014 FSM states: IDLE, SERVE, DONE; IDLE->SERVE when req_a or req_b is high; SERVE->DONE unconditionally; DONE->IDLE unconditionally.
REQ-015 In IDLE with a request, the block selects a winner and registers its we, addr and wdata plus a grant-owner bit at the clock edge entering SERVE.
REQ-016 Arbitration: round-robin; with both requests high, the winner is the requester not granted last; a single request always wins.
REQ-017 mem_addr and mem_wdata are always driven from the registered command; mem_write is high only during SERVE and only when the registered we is 1.
REQ-018 At the edge leaving SERVE, the owner's rdata register loads mem_rdata on a read; on a write, the owner's rdata register holds its value; the other requester's rdata register always holds.
REQ-019 In DONE, the owner's ack is high for exactly one cycle; the other ack stays low.
REQ-020 Latency: request sampled in IDLE at cycle N, memory access in cycle N+1, ack in cycle N+2; one transaction per 3 cycles at most.
REQ-021 Handshake: a requester holds req, we, addr and wdata stable until it sees ack, then drops req in the following cycle; a req still high in IDLE starts a new transaction.
REQ-022 Changes on a non-owner's request inputs during SERVE or DONE have no effect on the transaction in flight.
REQ-023 A read in SERVE returns the memory contents prior to any write in the same cycle; only one access occurs per transaction.
REQ-024 Address has no wrap logic; address values 0 and 2^word_size-1 pass through unmodified.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, ack_a = ack_b = 0, rdata_a = rdata_b = 0, mem_write = 0, registered command = 0, last-grant = B (A wins first contention).
REQ-026 Reset during SERVE aborts the access: mem_write falls immediately, no ack is issued, and the transaction is not replayed after reset.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN: when defined, requester A always wins contention and the last-grant register is omitted; when undefined, round-robin per REQ-016 applies.

Verification
REQ-028 Write A: req_a = 1, we_a = 1, addr_a = 8'h10, wdata_a = 8'hA5 -> mem_write is high in cycle N+1 only, with mem_addr = 8'h10; ack_a is high in cycle N+2.
REQ-029 Read-back B: req_b = 1, we_b = 0, addr_b = 8'h10 after REQ-028 -> rdata_b = 8'hA5 when ack_b is high; rdata_a is unchanged.
REQ-030 Contention after reset: req_a and req_b are held high continuously -> grants go A, B, A, B; acks are 3 cycles apart; with MEM_ARB_FIXED_PRIO_EN, the grants go A, A, A.
REQ-031 Boundary: write 8'hFF to addr 8'hFF and 8'h00 to addr 8'h00, then read both -> 8'hFF and 8'h00 are returned with no aliasing.
REQ-032 Reset in SERVE: rst_n is pulled low mid-cycle N+1 of a write -> mem_write drops immediately, no ack is issued, all outputs are 0, and the next request after release is granted to A.
REQ-033 Non-owner change: while A is served, addr_b and we_b toggle -> the memory transaction and ack_a timing are unaffected.
